// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream read port and one downstream write
// port between an instruction-fetch read requester and a data read/write
// requester. A registered grant spends one IDLE arbitration cycle per
// transaction. Writes win over data reads, data wins over fetch, and a
// starvation counter forces a fetch grant after STARVE_LIMIT data grants.
// Optional build macro: ARB_PERF_CNT_EN adds grant and conflict counters.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  // fetch read port
  input  logic        if_rdata_en,
  input  logic [31:0] if_rdata_addr,
  output logic [31:0] if_rdata,
  output logic        if_rdata_stall,
  // data read port
  input  logic        d_rdata_en,
  input  logic [31:0] d_rdata_addr,
  output logic [31:0] d_rdata,
  output logic        d_rdata_stall,
  // data write port
  input  logic        d_wdata_en,
  input  logic [31:0] d_wdata_addr,
  input  logic [3:0]  d_wdata_byte_en,
  input  logic [31:0] d_wdata,
  output logic        d_wdata_stall,
  // shared downstream read port
  output logic        m_rdata_en,
  output logic [31:0] m_rdata_addr,
  input  logic [31:0] m_rdata,
  input  logic        m_rdata_stall,
  // shared downstream write port
  output logic        m_wdata_en,
  output logic [31:0] m_wdata_addr,
  output logic [3:0]  m_wdata_byte_en,
  output logic [31:0] m_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_if_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_conflict,
`else
`endif
  input  logic        m_wdata_stall
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DR, GNT_DW} state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] starve_cnt;

  // Grant register; asynchronous clear drops any grant at once.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-grant selection and port steering for the current grant.
  // NOTE: every output gets a default first, so no path leaves a variable
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state_q;
    m_rdata_en      = 1'b0;
    m_rdata_addr    = '0;
    m_wdata_en      = 1'b0;
    m_wdata_addr    = '0;
    m_wdata_byte_en = '0;
    m_wdata         = '0;
    if_rdata        = '0;
    d_rdata         = '0;
    // a waiting requester stalls only while it is actually asking
    if_rdata_stall  = if_rdata_en;
    d_rdata_stall   = d_rdata_en;
    d_wdata_stall   = d_wdata_en;

    unique case (state_q)
      IDLE: begin
        if (if_rdata_en && starve_cnt == LIMIT_C) state_nxt = GNT_IF;
        else if (d_wdata_en)                      state_nxt = GNT_DW;
        else if (d_rdata_en)                      state_nxt = GNT_DR;
        else if (if_rdata_en)                     state_nxt = GNT_IF;
      end
      GNT_IF: begin
        m_rdata_en     = if_rdata_en;
        m_rdata_addr   = if_rdata_addr;
        if_rdata       = m_rdata;
        if_rdata_stall = m_rdata_stall;
        // completion or flush (en dropped) both release the grant
        if (!if_rdata_en || !m_rdata_stall) state_nxt = IDLE;
      end
      GNT_DR: begin
        m_rdata_en    = d_rdata_en;
        m_rdata_addr  = d_rdata_addr;
        d_rdata       = m_rdata;
        d_rdata_stall = m_rdata_stall;
        if (!d_rdata_en || !m_rdata_stall) state_nxt = IDLE;
      end
      GNT_DW: begin
        m_wdata_en      = d_wdata_en;
        m_wdata_addr    = d_wdata_addr;
        m_wdata_byte_en = d_wdata_byte_en;
        m_wdata         = d_wdata;
        d_wdata_stall   = m_wdata_stall;
        if (!d_wdata_en || !m_wdata_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Starvation counter: counts data grants taken while fetch waits, saturating.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      starve_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (state_nxt == GNT_IF) begin
        starve_cnt <= '0;
      end else if ((state_nxt == GNT_DR || state_nxt == GNT_DW) &&
                   if_rdata_en && starve_cnt != LIMIT_C) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Performance counters: grant entries per requester and contended IDLE cycles.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      perf_if_gnt   <= '0;
      perf_d_gnt    <= '0;
      perf_conflict <= '0;
    end else if (state_q == IDLE) begin
      if (state_nxt == GNT_IF)
        perf_if_gnt <= perf_if_gnt + 32'd1;
      if (state_nxt == GNT_DR || state_nxt == GNT_DW)
        perf_d_gnt <= perf_d_gnt + 32'd1;
      if (if_rdata_en && (d_rdata_en || d_wdata_en))
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`else
  // Performance counters are not present in this build.
`endif

endmodule
